// File: rtl/des_sbox_layer.sv
// DES substitution layer: eight FIPS 46-3 S-boxes applied to a 48-bit half-block,
// evaluated SBOX_PER_CYCLE boxes per clock behind valid/ready handshakes.
module des_sbox_layer #(
    parameter int SBOX_PER_CYCLE = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [47:0] DataIn,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] DataOut,
    output logic        Busy
);

    localparam int ITER  = 8 / SBOX_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int LW    = 4 * SBOX_PER_CYCLE;
    localparam int SW    = 6 * SBOX_PER_CYCLE;

    generate
        if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 ||
              SBOX_PER_CYCLE == 4 || SBOX_PER_CYCLE == 8)) begin : g_bad_param
            $error("des_sbox_layer: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One 64-nibble ROM per box, row-major: entry (row*16 + col) sits at nibble [255-4n -: 4].
    localparam logic [255:0] SBOX_ROM [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    state_t           state_q, state_d;
    logic [47:0]      in_reg_q, in_reg_d;
    logic [31:0]      acc_reg_q, acc_reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LW-1:0]    lookups;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        logic [5:0]   chunk;
        logic [2:0]   box;
        logic [5:0]   idx;
        logic [255:0] rom;
        lookups = '0;
        chunk   = '0;
        box     = '0;
        idx     = '0;
        rom     = '0;
        for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
            chunk = in_reg_q[47-6*k -: 6];
            box   = 3'(int'(cnt_q) * SBOX_PER_CYCLE + k);
            // Outer bits select the row, inner four the column.
            idx   = {chunk[5], chunk[0], chunk[4:1]};
            rom   = SBOX_ROM[box];
            lookups[LW-1-4*k -: 4] = rom[255-4*int'(idx) -: 4];
        end
    end

    always_comb begin
        state_d   = state_q;
        in_reg_d  = in_reg_q;
        acc_reg_d = acc_reg_q;
        cnt_d     = cnt_q;
        InReady   = 1'b0;
        case (state_q)
            IDLE: InReady = 1'b1;
            BUSY: begin
                acc_reg_d = (acc_reg_q << LW) | 32'(lookups);
                in_reg_d  = in_reg_q << SW;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                InReady = OutReady;
                if (OutReady && !InValid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (InReady && InValid) begin
            in_reg_d = DataIn;
            cnt_d    = '0;
            state_d  = BUSY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            in_reg_q  <= '0;
            acc_reg_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_reg_q  <= in_reg_d;
            acc_reg_q <= acc_reg_d;
            cnt_q     <= cnt_d;
        end
    end

    assign OutValid = (state_q == DONE);
    assign Busy     = (state_q == BUSY);
    assign DataOut  = acc_reg_q;

endmodule

// File: tb/tb_des_sbox_layer.sv
// Self-checking bench for des_sbox_layer: one lane per legal SBOX_PER_CYCLE, each with
// its own directed stimulus, expected-value queue and output monitor.
module tb_des_sbox_layer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIPS 46-3 tables as [box][row][col].
    localparam int S_TAB [8][4][16] = '{
        '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
          '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
          '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
          '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
        '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
          '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
          '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
          '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
        '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
          '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
          '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
          '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
        '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
          '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
          '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
          '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
        '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
          '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
          '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
          '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
        '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
          '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
          '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
          '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
        '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
          '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
          '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
          '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
        '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
          '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
          '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
          '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}
    };

    // S7 output for raw chunk values 0..63, nibble i at [255-4i -: 4].
    localparam logic [255:0] S7_RAW =
        256'h4DB02BE7F40981DA3EC3957C52AF6816_164BBDD8C1347AE7A9F5608F0E52932C;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sbox_model(input logic [47:0] x);
        logic [31:0] r;
        logic [5:0]  c;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            c = x[47-6*b -: 6];
            r[31-4*b -: 4] = 4'(S_TAB[b][{c[5], c[0]}][c[4:1]]);
        end
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int P  = 1 << g;
        localparam int IT = 8 / P;

        logic        rst;
        logic        in_valid;
        logic        in_ready;
        logic [47:0] data_in;
        logic        out_valid;
        logic        out_ready;
        logic [31:0] data_out;
        logic        busy;
        logic        done = 1'b0;
        logic [31:0] exp_q [$];

        des_sbox_layer #(.SBOX_PER_CYCLE(P)) dut (
            .Clk      (clk),
            .Reset    (rst),
            .InValid  (in_valid),
            .InReady  (in_ready),
            .DataIn   (data_in),
            .OutValid (out_valid),
            .OutReady (out_ready),
            .DataOut  (data_out),
            .Busy     (busy)
        );

        // Monitor: a handshake completes at the next rising edge.
        always @(negedge clk) begin
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check($sformatf("P%0d_unexpected_output_queue_size", P), 64'(exp_q.size()), 64'd1);
                else
                    check($sformatf("P%0d_sb_data", P), 64'(data_out), 64'(exp_q.pop_front()));
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        // Issue one block, then count cycles to OutValid while checking Busy.
        task automatic send_and_time(input logic [47:0] d, input logic [31:0] exp, input string tag);
            int k;
            in_valid = 1'b1;
            data_in  = d;
            #1;
            check($sformatf("P%0d_%s_in_ready", P, tag), 64'(in_ready), 64'd1);
            exp_q.push_back(exp);
            tick();
            in_valid = 1'b0;
            data_in  = ~d;
            k = 0;
            while (!out_valid && k < 40) begin
                check($sformatf("P%0d_%s_busy", P, tag), 64'(busy), 64'd1);
                tick();
                k++;
            end
            check($sformatf("P%0d_%s_latency", P, tag), 64'(k), 64'(IT));
        endtask

        initial begin
            logic [255:0] s7_tab;
            logic [47:0]  a, b, d;
            logic [63:0]  r;
            int           n, cyc;
            s7_tab    = S7_RAW;
            rst       = 1'b1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            data_in   = '0;
            tick();
            tick();
            check($sformatf("P%0d_rst_out_valid", P), 64'(out_valid), 64'd0);
            check($sformatf("P%0d_rst_busy", P), 64'(busy), 64'd0);
            check($sformatf("P%0d_rst_data_out", P), 64'(data_out), 64'd0);
            check($sformatf("P%0d_rst_in_ready", P), 64'(in_ready), 64'd1);
            rst = 1'b0;
            tick();

            send_and_time(48'h000000000000, 32'hEFA72C4D, "zeros");
            tick();
            send_and_time(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "ones");
            tick();

            for (int i = 0; i < 64; i++) begin
                send_and_time(48'(i) << 6, {24'hEFA72C, s7_tab[255-4*i -: 4], 4'hD}, "s7");
                tick();
            end

            // Backpressure: result must hold while the next block waits.
            out_ready = 1'b0;
            a = 48'h123456789ABC;
            b = 48'hFEDCBA987654;
            send_and_time(a, sbox_model(a), "bp_a");
            in_valid = 1'b1;
            data_in  = b;
            #1;
            for (int c = 0; c < 5; c++) begin
                check($sformatf("P%0d_bp_hold_data", P), 64'(data_out), 64'(sbox_model(a)));
                check($sformatf("P%0d_bp_out_valid", P), 64'(out_valid), 64'd1);
                check($sformatf("P%0d_bp_in_ready", P), 64'(in_ready), 64'd0);
                tick();
            end
            out_ready = 1'b1;
            send_and_time(b, sbox_model(b), "bp_b");
            tick();

            // Streaming with both sides held ready.
            n   = 0;
            cyc = 0;
            r   = {$urandom(), $urandom()};
            d   = r[47:0];
            in_valid = 1'b1;
            while (n < 16 && cyc < 400) begin
                data_in = d;
                #1;
                if (in_ready) begin
                    exp_q.push_back(sbox_model(d));
                    n++;
                    r = {$urandom(), $urandom()};
                    d = r[47:0];
                end
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            check($sformatf("P%0d_stream_accepted", P), 64'(n), 64'd16);
            for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
            check($sformatf("P%0d_stream_drained", P), 64'(exp_q.size()), 64'd0);
            tick();

            // Reset two cycles after acceptance aborts the block.
            out_ready = 1'b0;
            in_valid  = 1'b1;
            data_in   = 48'h0F1E2D3C4B5A;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            rst = 1'b1;
            #1;
            check($sformatf("P%0d_abort_out_valid", P), 64'(out_valid), 64'd0);
            check($sformatf("P%0d_abort_busy", P), 64'(busy), 64'd0);
            check($sformatf("P%0d_abort_data_out", P), 64'(data_out), 64'd0);
            check($sformatf("P%0d_abort_in_ready", P), 64'(in_ready), 64'd1);
            tick();
            rst       = 1'b0;
            out_ready = 1'b1;
            tick();
            send_and_time(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "after_abort");
            tick();
            tick();
            check($sformatf("P%0d_final_queue_empty", P), 64'(exp_q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        logic all_done;
        all_done = 1'b0;
        for (int c = 0; c < 60000 && !all_done; c++) begin
            @(posedge clk);
            all_done = lane[0].done && lane[1].done && lane[2].done && lane[3].done;
        end
        check("all_lanes_done", 64'(all_done), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
